// File: rtl/screen_compositor.sv
// rtl/screen_compositor.sv - windowed ROM screen selector with button background and blink
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   bright              display-active flag aligned with hCount/vCount
//   hCount, vCount      current raster column/row
//   screen_sel          requested screen index, qualified by sel_valid strobe
//   blink_en            level, blinks the window between screen and background
//   btn                 {up, right, down, left} background colour buttons
//   pix_in              flat ROM outputs, screen k at [12k+11:12k], ROM_LAT cycles late
//   rgb                 registered pixel colour, ROM_LAT+1 cycles after coordinates
//   sel_active          screen currently displayed
//   frame_start         one-cycle pulse the cycle after hCount==0 && vCount==0
module screen_compositor #(
  parameter int NUM_SCREENS  = 8,
  parameter int SEL_W        = 3,
  parameter int ROM_LAT      = 1,
  parameter int WIN_X        = 143,
  parameter int WIN_Y        = 34,
  parameter int WIN_W        = 640,
  parameter int WIN_H        = 480,
  parameter int HOLD_FRAMES  = 30,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bright,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic [SEL_W-1:0]          screen_sel,
  input  logic                      sel_valid,
  input  logic                      blink_en,
  input  logic [3:0]                btn,
  input  logic [12*NUM_SCREENS-1:0] pix_in,
  output logic [11:0]               rgb,
  output logic [SEL_W-1:0]          sel_active,
  output logic                      frame_start
);

  // 11-bit bounds so WIN_X+WIN_W-1 cannot wrap against a 10-bit counter
  localparam logic [10:0]    X_LO       = 11'(WIN_X);
  localparam logic [10:0]    X_HI       = 11'(WIN_X + WIN_W - 1);
  localparam logic [10:0]    Y_LO       = 11'(WIN_Y);
  localparam logic [10:0]    Y_HI       = 11'(WIN_Y + WIN_H - 1);
  localparam logic [SEL_W:0] NUM_SEL    = (SEL_W + 1)'(NUM_SCREENS);
  localparam logic [7:0]     HOLD_INIT  = 8'(HOLD_FRAMES);
  localparam logic [7:0]     BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic               fs;
  logic               sel_ok;
  logic               in_win;
  logic [11:0]        btn_col;
  logic [11:0]        pix_sel;

  logic [SEL_W-1:0]   sel_pending_q, sel_pending_d;
  logic [SEL_W-1:0]   sel_active_q, sel_active_d;
  logic [11:0]        bg_q, bg_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [ROM_LAT-1:0] bright_sr_q, bright_sr_d;
  logic [ROM_LAT-1:0] win_sr_q, win_sr_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               frame_start_q;

  assign fs     = (hCount == 10'd0) && (vCount == 10'd0);
  assign sel_ok = sel_valid && ({1'b0, screen_sel} < NUM_SEL);
  assign in_win = ({1'b0, hCount} >= X_LO) && ({1'b0, hCount} <= X_HI) &&
                  ({1'b0, vCount} >= Y_LO) && ({1'b0, vCount} <= Y_HI);

  // up > right > down > left
  always_comb begin
    btn_col = 12'h0F0;
    if (btn[3])      btn_col = 12'hF00;
    else if (btn[2]) btn_col = 12'h01F;
    else if (btn[1]) btn_col = 12'hFF0;
  end

  always_comb begin
    pix_sel = 12'h000;
    for (int k = 0; k < NUM_SCREENS; k++) begin
      if (sel_active_q == SEL_W'(k)) pix_sel = pix_in[12*k +: 12];
    end
  end

  always_comb begin
    sel_pending_d = sel_pending_q;
    if (sel_ok) sel_pending_d = screen_sel;

    // a valid strobe landing on fs bypasses the pending register
    sel_active_d = sel_active_q;
    if (fs) sel_active_d = sel_ok ? screen_sel : sel_pending_q;

    // a press beats the frame-start decrement
    bg_d   = bg_q;
    hold_d = hold_q;
    if (|btn) begin
      bg_d   = btn_col;
      hold_d = HOLD_INIT;
    end else if (fs && (hold_q != 8'd0)) begin
      hold_d = hold_q - 8'd1;
      if (hold_q == 8'd1) bg_d = 12'h000;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink_en) begin
      blink_cnt_d   = 8'd0;
      blink_phase_d = 1'b0;
    end else if (fs) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end

    // delay bright/window by the ROM latency so they meet the ROM data
    bright_sr_d    = bright_sr_q << 1;
    bright_sr_d[0] = bright;
    win_sr_d       = win_sr_q << 1;
    win_sr_d[0]    = in_win;

    if (!bright_sr_q[ROM_LAT-1])                        rgb_d = 12'h000;
    else if (win_sr_q[ROM_LAT-1] && !blink_phase_q)     rgb_d = pix_sel;
    else                                                rgb_d = bg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_pending_q <= '0;
      sel_active_q  <= '0;
      bg_q          <= 12'hFFF;
      hold_q        <= HOLD_INIT;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b0;
      bright_sr_q   <= '0;
      win_sr_q      <= '0;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      sel_pending_q <= sel_pending_d;
      sel_active_q  <= sel_active_d;
      bg_q          <= bg_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bright_sr_q   <= bright_sr_d;
      win_sr_q      <= win_sr_d;
      rgb_q         <= rgb_d;
      frame_start_q <= fs;
    end
  end

  assign rgb         = rgb_q;
  assign sel_active  = sel_active_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_screen_compositor.sv
// tb/tb_screen_compositor.sv - scoreboard bench for screen_compositor on a reduced 40x20 raster
module tb_screen_compositor;

  localparam int NS    = 6;
  localparam int H_TOT = 40;
  localparam int V_TOT = 20;
  localparam int FRAME = H_TOT * V_TOT;

  logic              clk = 1'b0;
  logic              rst;
  logic              bright;
  logic [9:0]        hCount, vCount;
  logic [2:0]        screen_sel;
  logic              sel_valid;
  logic              blink_en;
  logic [3:0]        btn;
  logic [12*NS-1:0]  pix;
  logic [11:0]       rgb1, rgb3;
  logic [2:0]        sa1, sa3;
  logic              fs1, fs3;

  int                n_vec = 0;
  int                n_bad = 0;
  int                cur_idx;
  int                exp_sel_g;
  logic [11:0]       q1[$];
  logic [11:0]       q3[$];

  always #5 clk = ~clk;

  screen_compositor #(
    .NUM_SCREENS(NS), .SEL_W(3), .ROM_LAT(1), .WIN_X(10), .WIN_Y(5), .WIN_W(16), .WIN_H(8),
    .HOLD_FRAMES(2), .BLINK_FRAMES(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .screen_sel(screen_sel), .sel_valid(sel_valid), .blink_en(blink_en), .btn(btn),
    .pix_in(pix), .rgb(rgb1), .sel_active(sa1), .frame_start(fs1)
  );

  screen_compositor #(
    .NUM_SCREENS(NS), .SEL_W(3), .ROM_LAT(3), .WIN_X(10), .WIN_Y(5), .WIN_W(16), .WIN_H(8),
    .HOLD_FRAMES(2), .BLINK_FRAMES(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .screen_sel(screen_sel), .sel_valid(sel_valid), .blink_en(blink_en), .btn(btn),
    .pix_in(pix), .rgb(rgb3), .sel_active(sa3), .frame_start(fs3)
  );

  // bright region h 4..35, v 2..17; window h 10..25, v 5..12; screen k shows 12'h210+k
  function automatic logic [11:0] exp_pix(input int h, input int v, input int sel,
                                           input logic [11:0] bg, input bit hide);
    if (!(h >= 4 && h < 36 && v >= 2 && v < 18)) return 12'h000;
    if (h >= 10 && h <= 25 && v >= 5 && v <= 12 && !hide) return 12'h210 + 12'(sel);
    return bg;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h", name, cur_idx, got, want);
    end
  endtask

  // monitor: one rgb per clock leaves each DUT; pop the expectation queued ROM_LAT+1 pixels ago
  initial begin
    logic [11:0] e;
    bit rst_seen;
    rst_seen = 1'b0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        if (!rst_seen) begin
          rst_seen = 1'b1;
          #1;
          chk("rst_rgb_lat1", int'(rgb1), 0);
          chk("rst_rgb_lat3", int'(rgb3), 0);
          chk("rst_sel_lat1", int'(sa1), 0);
          chk("rst_sel_lat3", int'(sa3), 0);
        end
      end else begin
        rst_seen = 1'b0;
        while (q1.size() > 2) begin
          e = q1.pop_front();
          chk("rgb_lat1", int'(rgb1), int'(e));
        end
        while (q3.size() > 4) begin
          e = q3.pop_front();
          chk("rgb_lat3", int'(rgb3), int'(e));
        end
        if (cur_idx == 1) begin
          chk("frame_start_lat1", int'(fs1), 1);
          chk("frame_start_lat3", int'(fs3), 1);
          chk("sel_active_lat1", int'(sa1), exp_sel_g);
          chk("sel_active_lat3", int'(sa3), exp_sel_g);
        end
        if (cur_idx == 2) begin
          chk("frame_start_end_lat1", int'(fs1), 0);
          chk("frame_start_end_lat3", int'(fs3), 0);
        end
      end
    end
  end

  task automatic run_frame(input int sel, input logic [11:0] bg, input bit hide, input bit blink,
                           input int st1_i, input int st1_v, input int st2_i, input int st2_v,
                           input int btn_i, input logic [3:0] btn_v, input int rst_i, input int rel_i);
    int h, v;
    logic [11:0] e;
    exp_sel_g = sel;
    for (int idx = 0; idx < FRAME; idx++) begin
      h = idx % H_TOT;
      v = idx / H_TOT;
      @(posedge clk);
      #1;
      if (idx == rel_i) begin
        // pipeline restarts empty: ROM_LAT black pixels precede the first real one
        rst = 1'b0;
        q1.delete();
        q3.delete();
        q1.push_back(12'h000);
        repeat (3) q3.push_back(12'h000);
        sel = 0;
        bg = 12'hFFF;
        hide = 1'b0;
        exp_sel_g = 0;
      end
      hCount     = 10'(h);
      vCount     = 10'(v);
      bright     = (h >= 4 && h < 36 && v >= 2 && v < 18);
      blink_en   = blink;
      sel_valid  = (idx == st1_i) || (idx == st2_i);
      screen_sel = (idx == st2_i) ? 3'(st2_v) : 3'(st1_v);
      btn        = (btn_i >= 0 && idx >= btn_i && idx < btn_i + 10) ? btn_v : 4'b0000;
      cur_idx    = idx;
      if (!rst) begin
        e = exp_pix(h, v, sel, bg, hide);
        q1.push_back(e);
        q3.push_back(e);
      end
      if (idx == rst_i) begin
        @(negedge clk);
        #2;
        rst = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hCount = 10'd39; vCount = 10'd19; bright = 1'b0;
    sel_valid = 1'b0; screen_sel = 3'd0; blink_en = 1'b0; btn = 4'b0000;
    cur_idx = -1; exp_sel_g = 0;
    for (int k = 0; k < NS; k++) pix[12*k +: 12] = 12'h210 + 12'(k);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.push_back(12'h000);
    repeat (3) q3.push_back(12'h000);
    q1.push_back(12'h000);
    q3.push_back(12'h000);

    // A: white background, screen 0; strobe 5 before window, 3 mid-window
    run_frame(0, 12'hFFF, 0, 0, 140, 5, 412, 3, -1, 4'b0000, -1, -1);
    // B: screen 3 committed, white decayed; out-of-range 6 strobed
    run_frame(3, 12'h000, 0, 0, 325, 6, -1, 0, -1, 4'b0000, -1, -1);
    run_frame(3, 12'h000, 0, 0, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    // D: up pressed in vblank
    run_frame(3, 12'h000, 0, 0, -1, 0, -1, 0, 730, 4'b1000, -1, -1);
    run_frame(3, 12'hF00, 0, 0, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    // F: up+left pressed
    run_frame(3, 12'h000, 0, 0, -1, 0, -1, 0, 730, 4'b1001, -1, -1);
    run_frame(3, 12'hF00, 0, 0, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    // H: right+down pressed
    run_frame(3, 12'h000, 0, 0, -1, 0, -1, 0, 730, 4'b0110, -1, -1);
    run_frame(3, 12'h01F, 0, 0, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    // J..N: blink on, down pressed in J so the hidden window is yellow in K
    run_frame(3, 12'h000, 0, 1, -1, 0, -1, 0, 730, 4'b0010, -1, -1);
    run_frame(3, 12'hFF0, 1, 1, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    run_frame(3, 12'h000, 1, 1, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    run_frame(3, 12'h000, 0, 1, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    run_frame(3, 12'h000, 0, 1, -1, 0, -1, 0, -1, 4'b0000, -1, -1);
    // O: blink off, reset inside window at (15,8), released at (19,8)
    run_frame(3, 12'h000, 0, 0, -1, 0, -1, 0, -1, 4'b0000, 335, 339);
    // P: state back at reset values, white still held
    run_frame(0, 12'hFFF, 0, 0, -1, 0, -1, 0, -1, 4'b0000, -1, -1);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
